mmio_uart_tohost: RTL and testbench

Memory-mapped peripheral on the CPU data-memory store/load port. It decodes a 3-word window at `BASE_ADDR` and provides three functions:
- a TOHOST mailbox that latches the test result and drives `done`, `pass` and `led`;
- a 4-entry TX FIFO feeding an 8N1 UART transmitter;
- a status register.

It sits directly downstream of the CPU data path, in parallel with data memory. The top level muxes `rdata` when `hit` is high.

---
 rtl/mmio_uart_tohost_if.sv | 16 +
 rtl/mmio_uart_tohost.sv | 193 +++++++++++++++++++
 tb/tb_mmio_uart_tohost.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tohost_if.sv
// CPU data-port view of the tohost/UART peripheral: byte address, store data and strobes in; decode hit and read data out.
// Latency: hit is combinational from addr; rdata is registered (one cycle after the load strobe).
// Backpressure: none; stores to a full TX FIFO are dropped and reported through the status overflow bit.
interface mmio_uart_tohost_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] addr;   // byte address, bits [1:0] ignored
   logic [31:0]           wdata;  // store data
   logic                  wen;    // store strobe
   logic                  ren;    // load strobe
   logic                  hit;    // address falls in the 3-word window
   logic [31:0]           rdata;  // registered load data

   modport master (output addr, wdata, wen, ren, input hit, rdata);
   modport slave  (input addr, wdata, wen, ren, output hit, rdata);
endinterface

// File: rtl/mmio_uart_tohost.sv
// TOHOST mailbox + 4-entry TX FIFO feeding an 8N1 UART, + status word, decoded at BASE_ADDR+0/4/8.
// Latency: loads return one cycle after ren; a TXDATA store into an idle block pops on the next edge, tx falls after it.
// Backpressure: none on the bus; a TXDATA store while the FIFO is full is dropped and sets the sticky overflow bit.
// Ports: sysclk/rst (async active-low), bus (slave side of mmio_uart_tohost_if),
//        tx (UART line, idle high), done/pass/led (test result from the TOHOST word).
module mmio_uart_tohost #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 16'h4000,
   parameter int                    CLKS_PER_BIT = 868,
   parameter int                    FIFO_DEPTH   = 4
) (
   input  logic                     sysclk,
   input  logic                     rst,
   mmio_uart_tohost_if.slave        bus,
   output logic                     tx,
   output logic                     done,
   output logic                     pass,
   output logic                     led
);

   localparam int WW = ADDR_WIDTH - 2;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [WW-1:0] W_TOHOST = BASE_ADDR[ADDR_WIDTH-1:2];
   localparam logic [WW-1:0] W_TXDATA = W_TOHOST + WW'(1);
   localparam logic [WW-1:0] W_STATUS = W_TOHOST + WW'(2);
   localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_FULL   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   // ---------------- address decode ----------------
   logic [WW-1:0] word;
   logic          sel_tohost, sel_txdata, sel_status, hit;
   logic          wr_tohost, wr_txdata, wr_status;
   logic          unused_addr_lsb;

   assign word       = bus.addr[ADDR_WIDTH-1:2];
   assign sel_tohost = (word == W_TOHOST);
   assign sel_txdata = (word == W_TXDATA);
   assign sel_status = (word == W_STATUS);
   assign hit        = sel_tohost | sel_txdata | sel_status;
   assign bus.hit    = hit;

   assign wr_tohost  = bus.wen & sel_tohost;
   assign wr_txdata  = bus.wen & sel_txdata;
   assign wr_status  = bus.wen & sel_status;

   // Word-addressed registers: the byte offset is deliberately ignored.
   assign unused_addr_lsb = ^bus.addr[1:0];

   // ---------------- TOHOST mailbox ----------------
   logic [31:0] tohost;

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         tohost <= '0;
         done   <= 1'b0;
         pass   <= 1'b0;
      end else if (wr_tohost) begin
         tohost <= bus.wdata;
         done   <= 1'b1;
         pass   <= (bus.wdata == 32'd1);
      end
   end

   assign led = pass;

   // ---------------- TX FIFO ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full, push_ok, push_drop, pop, ovf;

   assign empty     = (count == '0);
   assign full      = (count == C_FULL);
   // Fullness is judged on the pre-edge count, so a pop on the same edge does not rescue a push.
   assign push_ok   = wr_txdata & ~full;
   assign push_drop = wr_txdata & full;

   always_ff @(posedge sysclk) begin
      if (push_ok) begin
         mem[wr_ptr] <= bus.wdata[7:0];
      end
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (!push_ok && pop) count <= count - 1'b1;
         if (push_drop)      ovf <= 1'b1;
         else if (wr_status) ovf <= 1'b0;
      end
   end

   // ---------------- UART transmitter ----------------
   tx_state_t     state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shreg;
   logic          timer_last, busy;

   assign timer_last = (timer == T_LAST);
   assign busy       = (state != IDLE);

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         bit_idx <= bit_idx_nxt;
         if (pop) shreg <= mem[rd_ptr];
      end
   end

   // tx is decoded from state registers only, so reset forces the line high immediately.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer + 1'b1;
      bit_idx_nxt = bit_idx;
      pop         = 1'b0;
      tx          = 1'b1;
      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (timer_last) begin
               timer_nxt   = '0;
               bit_idx_nxt = '0;
               state_nxt   = DATA;
            end
         end
         DATA: begin
            tx = shreg[bit_idx];
            if (timer_last) begin
               timer_nxt = '0;
               if (bit_idx == 3'd7) state_nxt = STOP;
               else                 bit_idx_nxt = bit_idx + 1'b1;
            end
         end
         STOP: begin
            if (timer_last) begin
               timer_nxt = '0;
               // Chain straight into the next start bit to keep frames contiguous.
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- read path ----------------
   logic [31:0] rd_mux, rdata_q;

   always_comb begin
      rd_mux = '0;
      if (sel_tohost)      rd_mux = tohost;
      else if (sel_status) rd_mux = {26'd0, pass, done, ovf, busy, full, empty};
   end

   // Sampled from pre-edge state, so a load paired with a store sees the old value.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) rdata_q <= '0;
      else      rdata_q <= bus.ren ? rd_mux : 32'd0;
   end

   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tohost.sv
// Bench for mmio_uart_tohost: directed scenarios plus a randomized phase, all checked against a frame-level model.
// Latency: model updates on each rising edge; outputs are compared 1 time unit later.
// Backpressure: none; the model drops TXDATA stores when its queue already holds FIFO_DEPTH bytes.
module tb_mmio_uart_tohost;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam int          FRAME = 10 * CPB;
   localparam logic [15:0] BASE  = 16'h4000;

   logic sysclk = 1'b0;
   logic rst    = 1'b0;
   logic tx, done, pass, led;

   mmio_uart_tohost_if #(.ADDR_WIDTH(16)) bus();

   mmio_uart_tohost #(
      .ADDR_WIDTH(16), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .sysclk(sysclk), .rst(rst), .bus(bus), .tx(tx), .done(done), .pass(pass), .led(led)
   );

   always #5 sysclk = ~sysclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mq[$];      // bytes waiting in the FIFO
   bit          m_active;   // a frame is on the line
   int          m_pos;      // cycle position inside the current frame
   logic [7:0]  m_cur;
   bit          m_ovf, m_done, m_pass;
   logic [31:0] m_tohost, m_rdata;

   function automatic int woff(input logic [15:0] a);
      int w;
      w = int'(a >> 2) - int'(BASE >> 2);
      return (w >= 0 && w <= 2) ? w : -1;
   endfunction

   function automatic logic m_tx();
      if (!m_active)          return 1'b1;
      if (m_pos < CPB)        return 1'b0;
      if (m_pos < 9 * CPB)    return m_cur[(m_pos - CPB) / CPB];
      return 1'b1;
   endfunction

   task automatic model_step();
      int          off;
      bit          full, empty, pop;
      logic [31:0] rd;
      off   = woff(bus.addr);
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      rd    = '0;
      if (bus.ren) begin
         case (off)
            0:       rd = m_tohost;
            2:       rd = {26'd0, m_pass, m_done, m_ovf, m_active, full, empty};
            default: rd = '0;
         endcase
      end
      pop = !empty && (!m_active || m_pos == FRAME - 1);
      if (m_active && m_pos != FRAME - 1) m_pos++;
      else if (pop) begin
         m_cur    = mq.pop_front();
         m_active = 1'b1;
         m_pos    = 0;
      end else m_active = 1'b0;
      if (bus.wen) begin
         case (off)
            0: begin
               m_tohost = bus.wdata;
               m_done   = 1'b1;
               m_pass   = (bus.wdata == 32'd1);
            end
            1: begin
               if (full) m_ovf = 1'b1;
               else      mq.push_back(bus.wdata[7:0]);
            end
            2: m_ovf = 1'b0;
            default: ;
         endcase
      end
      m_rdata = rd;
   endtask

   always @(posedge sysclk) begin
      if (!rst) begin
         mq.delete();
         m_active = 1'b0; m_pos = 0; m_cur = '0;
         m_ovf = 1'b0; m_done = 1'b0; m_pass = 1'b0;
         m_tohost = '0; m_rdata = '0;
      end else begin
         model_step();
      end
      #1;
      check("cyc_tx",    {31'd0, tx},   {31'd0, m_tx()});
      check("cyc_done",  {31'd0, done}, {31'd0, m_done});
      check("cyc_pass",  {31'd0, pass}, {31'd0, m_pass});
      check("cyc_led",   {31'd0, led},  {31'd0, m_pass});
      check("cyc_rdata", bus.rdata,     m_rdata);
      check("cyc_hit",   {31'd0, bus.hit}, {31'd0, woff(bus.addr) >= 0});
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic w, input logic r);
      @(negedge sysclk);
      bus.addr = a; bus.wdata = d; bus.wen = w; bus.ren = r;
   endtask

   task automatic tick();
      @(posedge sysclk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(16'h0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int          bad, busy_cnt, first_low, j, low_cnt;
      logic [9:0]  fbits;
      logic        exp_tx;
      logic [15:0] a;
      logic [31:0] d;
      logic        w, r;
      int          sel;

      bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.ren = 1'b0;

      // Reset values
      repeat (3) @(negedge sysclk);
      #1;
      check("rst_tx",    {31'd0, tx},   32'd1);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_pass",  {31'd0, pass}, 32'd0);
      check("rst_led",   {31'd0, led},  32'd0);
      check("rst_rdata", bus.rdata,     32'd0);
      @(negedge sysclk);
      rst = 1'b1;
      drive(BASE + 16'd8, 32'd0, 1'b0, 1'b1);
      tick();
      check("rst_status", bus.rdata, 32'h1);

      // Single byte 0x55 with STATUS polled every cycle
      fbits = {1'b1, 8'h55, 1'b0};
      bad = 0; busy_cnt = 0; first_low = -1;
      drive(BASE + 16'd4, 32'h55, 1'b1, 1'b0);
      tick();
      if (tx !== 1'b1) bad++;
      for (int s = 1; s < 44; s++) begin
         drive(BASE + 16'd8, 32'd0, 1'b0, 1'b1);
         tick();
         exp_tx = (s >= 1 && s <= FRAME) ? fbits[(s - 1) / CPB] : 1'b1;
         if (tx !== exp_tx) bad++;
         if (tx === 1'b0 && first_low < 0) first_low = s;
         if (bus.rdata[2]) busy_cnt++;
      end
      check("single_tx_bits",    bad,       32'd0);
      check("single_first_low",  first_low, 32'd1);
      check("single_busy_count", busy_cnt,  32'd40);

      // Overflow: six writes while idle, fifth fills, sixth dropped
      for (int i = 0; i < 6; i++) drive(BASE + 16'd4, 32'h41 + i, 1'b1, 1'b0);
      drive(BASE + 16'd8, 32'd0, 1'b0, 1'b1);
      tick();
      check("ovf_status_flags", bus.rdata[3:0], 32'hE);
      j = 6;
      for (int k = 0; k < 400; k++) begin
         drive(BASE + 16'd8, 32'd0, 1'b0, 1'b1);
         tick();
         j++;
         if (!bus.rdata[2]) break;
      end
      check("ovf_first_idle_edge", j, 32'd202);
      check("ovf_sticky",          bus.rdata[3:0], 32'h9);
      drive(BASE + 16'd8, 32'd0, 1'b1, 1'b0);
      drive(BASE + 16'd8, 32'd0, 1'b0, 1'b1);
      tick();
      check("ovf_cleared", bus.rdata[3:0], 32'h1);

      // TOHOST result
      drive(BASE, 32'd1, 1'b1, 1'b0);
      tick();
      check("tohost1_done", {31'd0, done}, 32'd1);
      check("tohost1_pass", {31'd0, pass}, 32'd1);
      check("tohost1_led",  {31'd0, led},  32'd1);
      drive(BASE, 32'd3, 1'b1, 1'b0);
      tick();
      check("tohost3_done", {31'd0, done}, 32'd1);
      check("tohost3_pass", {31'd0, pass}, 32'd0);
      check("tohost3_led",  {31'd0, led},  32'd0);
      drive(BASE, 32'd0, 1'b0, 1'b1);
      tick();
      check("tohost_read", bus.rdata, 32'd3);

      // Decode boundaries and read-during-write
      drive(BASE - 16'd4, 32'd1, 1'b1, 1'b1);
      #1 check("dec_below_hit", {31'd0, bus.hit}, 32'd0);
      tick();
      check("dec_below_rdata", bus.rdata, 32'd0);
      drive(BASE + 16'd12, 32'd1, 1'b1, 1'b1);
      #1 check("dec_above_hit", {31'd0, bus.hit}, 32'd0);
      tick();
      check("dec_above_rdata", bus.rdata, 32'd0);
      drive(BASE + 16'd11, 32'd0, 1'b0, 1'b1);
      #1 check("dec_lsb_hit", {31'd0, bus.hit}, 32'd1);
      tick();
      check("dec_status_unchanged", bus.rdata, 32'h11);
      drive(BASE, 32'd7, 1'b1, 1'b1);
      tick();
      check("rw_same_old", bus.rdata, 32'd3);
      drive(BASE, 32'd0, 1'b0, 1'b1);
      tick();
      check("rw_same_new", bus.rdata, 32'd7);

      // Reset mid-frame
      for (int i = 0; i < 3; i++) drive(BASE + 16'd4, 32'h00, 1'b1, 1'b0);
      idle(9);
      tick();
      check("mid_frame_tx_low", {31'd0, tx}, 32'd0);
      @(negedge sysclk);
      rst = 1'b0;
      #1;
      check("midrst_tx",    {31'd0, tx},   32'd1);
      check("midrst_done",  {31'd0, done}, 32'd0);
      check("midrst_pass",  {31'd0, pass}, 32'd0);
      check("midrst_led",   {31'd0, led},  32'd0);
      check("midrst_rdata", bus.rdata,     32'd0);
      repeat (2) @(negedge sysclk);
      rst = 1'b1;
      drive(BASE + 16'd8, 32'd0, 1'b0, 1'b1);
      tick();
      check("midrst_status", bus.rdata, 32'h1);
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         drive(16'h0, 32'd0, 1'b0, 1'b0);
         tick();
         if (tx !== 1'b1) low_cnt++;
      end
      check("midrst_no_frames", low_cnt, 32'd0);

      // Randomized traffic, checked cycle by cycle against the model
      for (int c = 0; c < 3000; c++) begin
         sel = $urandom_range(0, 5);
         if (sel == 5) a = 16'($urandom);
         else          a = BASE - 16'd4 + 16'(4 * sel) + 16'($urandom_range(0, 3));
         d = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
         w = ($urandom_range(0, 3) == 0);
         r = 1'($urandom_range(0, 1));
         if (c == 1500) begin
            @(negedge sysclk);
            rst = 1'b0;
            repeat (3) @(negedge sysclk);
            rst = 1'b1;
         end
         drive(a, d, w, r);
      end
      idle(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
